// File: rtl/pwm_duty_loader_pkg.sv
// Shared constants and FSM encoding for the PWM duty loader.
package pwm_duty_loader_pkg;

    // Compare word that yields 50 % duty (zero control effort).
    localparam logic [11:0] CMP_MIDSCALE = 12'h800;

    // 16-bit signed clamp limits applied to incoming control samples.
    localparam int S16_MAX = 32767;
    localparam int S16_MIN = -32768;

    // Loader FSM: IDLE (nothing pending), CONV (formatting), PEND (waiting for period end).
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StConv = 2'd1,
        StPend = 2'd2
    } state_e;

endpackage

// File: rtl/pwm_sat_format.sv
// Saturates a wide signed sample to 16 bits and formats the offset-binary compare word.
module pwm_sat_format
    import pwm_duty_loader_pkg::*;
#(
    parameter int unsigned DW = 29,
    parameter int unsigned CW = 12
) (
    input  logic [DW-1:0] din_i,
    output logic [CW-1:0] word_o,
    output logic          clamped_o
);

    localparam logic signed [DW-1:0] SMax = DW'(S16_MAX);
    localparam logic signed [DW-1:0] SMin = DW'(S16_MIN);

    logic signed [DW-1:0] d;
    logic        [15:0]   s;
    logic        [15:0]   s_ob;

    assign d = $signed(din_i);

    // Clamp to the 16-bit signed range, flagging when a limit was applied.
    always_comb begin
        s         = din_i[15:0];
        clamped_o = 1'b0;
        if (d > SMax) begin
            s         = 16'h7FFF;
            clamped_o = 1'b1;
        end else if (d < SMin) begin
            s         = 16'h8000;
            clamped_o = 1'b1;
        end
    end

    // Offset binary: invert the sign bit, then keep the top CW bits (truncate, no rounding).
    assign s_ob   = {~s[15], s[14:0]};
    assign word_o = CW'(s_ob >> (16 - CW));

endmodule

// File: rtl/pwm_duty_loader.sv
// Double-buffered PWM duty loader with period-boundary commit and stale-input watchdog.
module pwm_duty_loader
    import pwm_duty_loader_pkg::*;
#(
    parameter int unsigned DW        = 29,
    parameter int unsigned CW        = 12,
    parameter int unsigned TIMEOUT_P = 16,
    parameter int unsigned OVR_W     = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [DW-1:0]    din_i,
    input  logic             din_valid_i,
    output logic             din_ready_o,
    input  logic             period_end_i,
    output logic [CW-1:0]    compare_out_o,
    output logic             stale_o,
    output logic             sat_flag_o,
    output logic [OVR_W-1:0] overrun_cnt_o
);

    localparam int unsigned      TW     = $clog2(TIMEOUT_P + 1);
    localparam logic [TW-1:0]    TmoMax = TW'(TIMEOUT_P);
    localparam logic [CW-1:0]    CmpMid = CW'(CMP_MIDSCALE);

    state_e           state_q, state_d;
    logic [DW-1:0]    sample_q, sample_d;
    logic [CW-1:0]    pending_q, pending_d;
    logic [CW-1:0]    cmp_q, cmp_d;
    logic             stale_q, stale_d;
    logic             sat_q, sat_d;
    logic [OVR_W-1:0] ovr_q, ovr_d;
    logic [TW-1:0]    tmo_q, tmo_d;

    logic [CW-1:0]    word;
    logic             clamped;
    logic             xfer;

    pwm_sat_format #(
        .DW (DW),
        .CW (CW)
    ) u_sat_format (
        .din_i     (sample_q),
        .word_o    (word),
        .clamped_o (clamped)
    );

    assign din_ready_o = (state_q != StConv);
    assign xfer        = din_valid_i && din_ready_o;

    // Next-state: sample capture, formatting, period-boundary commit and watchdog.
    always_comb begin
        state_d   = state_q;
        sample_d  = sample_q;
        pending_d = pending_q;
        cmp_d     = cmp_q;
        stale_d   = stale_q;
        sat_d     = sat_q;
        ovr_d     = ovr_q;
        tmo_d     = tmo_q;

        unique case (state_q)
            StIdle, StConv: begin
                if (state_q == StIdle) begin
                    if (xfer) begin
                        sample_d = din_i;
                        state_d  = StConv;
                    end
                end else begin
                    pending_d = word;
                    sat_d     = sat_q | clamped;
                    state_d   = StPend;
                end
                // No commit possible here, so a period end only advances the watchdog.
                if (period_end_i) begin
                    tmo_d = (tmo_q == TmoMax) ? tmo_q : tmo_q + 1'b1;
                    if (tmo_d == TmoMax) begin
                        cmp_d   = CmpMid;
                        stale_d = 1'b1;
                    end
                end
            end
            StPend: begin
                if (period_end_i) begin
                    cmp_d   = pending_q;
                    tmo_d   = '0;
                    stale_d = 1'b0;
                    state_d = StIdle;
                end
                if (xfer) begin
                    sample_d = din_i;
                    state_d  = StConv;
                    // Pending is lost only if it was not committed on this same edge.
                    if (!period_end_i && (ovr_q != '1)) begin
                        ovr_d = ovr_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and data registers; reset discards any pending sample.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            sample_q  <= '0;
            pending_q <= CmpMid;
            cmp_q     <= CmpMid;
            stale_q   <= 1'b0;
            sat_q     <= 1'b0;
            ovr_q     <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            sample_q  <= sample_d;
            pending_q <= pending_d;
            cmp_q     <= cmp_d;
            stale_q   <= stale_d;
            sat_q     <= sat_d;
            ovr_q     <= ovr_d;
            tmo_q     <= tmo_d;
        end
    end

    assign compare_out_o = cmp_q;
    assign stale_o       = stale_q;
    assign sat_flag_o    = sat_q;
    assign overrun_cnt_o = ovr_q;

endmodule

// File: tb/tb_pwm_duty_loader.sv
// Directed bench for pwm_duty_loader with immediate-assertion checks.
module tb_pwm_duty_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [28:0] din;
    logic        din_valid;
    logic        din_ready;
    logic        period_end;
    logic [11:0] compare_out;
    logic        stale;
    logic        sat_flag;
    logic [7:0]  overrun_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    pwm_duty_loader #(
        .DW        (29),
        .CW        (12),
        .TIMEOUT_P (16),
        .OVR_W     (8)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .din_i         (din),
        .din_valid_i   (din_valid),
        .din_ready_o   (din_ready),
        .period_end_i  (period_end),
        .compare_out_o (compare_out),
        .stale_o       (stale),
        .sat_flag_o    (sat_flag),
        .overrun_cnt_o (overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [28:0] d);
        din       = d;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic pulse();
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
    endtask

    task automatic load_commit(input logic [28:0] d);
        send(d);
        repeat (5) tick();
        pulse();
    endtask

    initial begin
        rst_n      = 1'b0;
        din        = 29'd5;
        din_valid  = 1'b1;
        period_end = 1'b0;
        repeat (3) tick();
        check("rst_compare", 32'(compare_out), 32'h800);
        check("rst_ready", 32'(din_ready), 32'h1);
        check("rst_stale", 32'(stale), 32'h0);
        check("rst_sat", 32'(sat_flag), 32'h0);
        check("rst_ovr", 32'(overrun_cnt), 32'h0);
        din_valid = 1'b0;
        rst_n     = 1'b1;
        tick();

        load_commit(29'd0);
        check("zero", 32'(compare_out), 32'h800);
        load_commit(29'd16);
        check("plus16", 32'(compare_out), 32'h801);
        load_commit(-29'sd16);
        check("minus16", 32'(compare_out), 32'h7FF);
        check("no_sat_yet", 32'(sat_flag), 32'h0);

        load_commit(29'd100000);
        check("sat_pos", 32'(compare_out), 32'hFFF);
        check("sat_flag", 32'(sat_flag), 32'h1);
        load_commit(-29'sd100000);
        check("sat_neg", 32'(compare_out), 32'h000);
        check("sat_sticky", 32'(sat_flag), 32'h1);

        // Period end while the sample is still being formatted must not commit it.
        send(29'h0100);
        check("conv_not_ready", 32'(din_ready), 32'h0);
        pulse();
        check("conv_no_commit", 32'(compare_out), 32'h000);
        pulse();
        check("conv_later_commit", 32'(compare_out), 32'h810);

        // Overwrite a pending sample before the boundary.
        send(29'h0100);
        tick();
        send(29'h0200);
        tick();
        check("ovr_one", 32'(overrun_cnt), 32'h1);
        pulse();
        check("ovr_commit", 32'(compare_out), 32'h820);

        // New sample accepted on the same edge that commits the old one.
        send(29'h0100);
        tick();
        din        = 29'h0300;
        din_valid  = 1'b1;
        period_end = 1'b1;
        tick();
        din_valid  = 1'b0;
        period_end = 1'b0;
        check("same_cycle_old", 32'(compare_out), 32'h810);
        check("same_cycle_ovr", 32'(overrun_cnt), 32'h1);
        tick();
        pulse();
        check("same_cycle_new", 32'(compare_out), 32'h830);

        for (int i = 0; i < 301; i++) begin
            send(29'(i));
            tick();
        end
        check("ovr_saturate", 32'(overrun_cnt), 32'hFF);

        // Watchdog: 15 empty periods keep the duty, the 16th falls back to midscale.
        send(29'h2000);
        tick();
        pulse();
        check("commit_A00", 32'(compare_out), 32'hA00);
        repeat (15) pulse();
        check("tmo_15_cmp", 32'(compare_out), 32'hA00);
        check("tmo_15_stale", 32'(stale), 32'h0);
        pulse();
        check("tmo_16_cmp", 32'(compare_out), 32'h800);
        check("tmo_16_stale", 32'(stale), 32'h1);
        pulse();
        check("tmo_hold", 32'(compare_out), 32'h800);
        send(29'h0100);
        tick();
        pulse();
        check("stale_clear", 32'(stale), 32'h0);
        check("stale_commit", 32'(compare_out), 32'h810);

        // Asynchronous reset while a sample is pending.
        send(29'h0400);
        tick();
        rst_n = 1'b0;
        #1;
        check("arst_cmp", 32'(compare_out), 32'h800);
        check("arst_ovr", 32'(overrun_cnt), 32'h0);
        check("arst_sat", 32'(sat_flag), 32'h0);
        rst_n = 1'b1;
        tick();
        pulse();
        tick();
        check("arst_discard", 32'(compare_out), 32'h800);
        check("arst_stale", 32'(stale), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
